// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM state encoding.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS wait-state counter with terminal-count compare; only built when APB_TIMEOUT_EN is defined.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    // Saturate at the terminal count so a stalled counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: one command at a time through SETUP/ACCESS, one-cycle response pulse.
// Optional ACCESS timeout abort is enabled with the macro APB_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | cmd_ready=1, waiting for cmd_valid
// ST_SETUP  | PSEL=1, PENABLE=0 for one cycle
// ST_ACCESS | PSEL=1, PENABLE=1 until PREADY (or timeout)
module apb_master
    import apb_pkg::*;
#(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_timeout_range
        $error("apb_master: TIMEOUT must be within 2..255");
    end

    apb_state_t        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [AWIDTH-1:0] paddr_q, paddr_d;
    logic [DWIDTH-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              timeout_hit;

`ifdef APB_TIMEOUT_EN
    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk (PCLK),
        .rst (PRESET),
        .clr (state_q == ST_SETUP),
        .inc ((state_q == ST_ACCESS) && !PREADY),
        .tc  (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    psel_d   = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                // A ready slave wins over a timeout landing on the same edge.
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    state_d     = ST_IDLE;
                end else if (timeout_hit) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: transaction-level model compared every cycle plus directed literals.
module tb_apb_master;

    localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL, PENABLE, PWRITE;
    logic [7:0] PADDR, PWDATA;
    logic [7:0] PRDATA = '0;
    logic       PREADY = 1'b1;
    logic       PSLVERR = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_rsp = 0;

    apb_master #(.AWIDTH(8), .DWIDTH(8), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;
    always @(negedge PCLK) if (rsp_valid === 1'b1) n_rsp <= n_rsp + 1;

    // Transaction model: m_age = clock edges seen since the command was taken.
    bit       m_active = 0;
    int       m_age = 0;
    bit       m_write = 0;
    bit [7:0] m_addr = 0, m_wdata = 0, m_rd = 0;
    bit       m_rv = 0, m_err = 0;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_active = 0; m_age = 0; m_write = 0; m_addr = 0; m_wdata = 0;
            m_rv = 0; m_rd = 0; m_err = 0;
        end else begin
            m_rv = 0;
            if (!m_active) begin
                if (cmd_valid) begin
                    m_active = 1; m_age = 0;
                    m_addr = cmd_addr; m_write = cmd_write;
                    m_wdata = cmd_write ? cmd_wdata : 8'h00;
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (PREADY) begin
                m_active = 0; m_rv = 1; m_err = PSLVERR;
                m_rd = m_write ? 8'h00 : PRDATA;
            end else if (TO_EN && m_age == TO) begin
                m_active = 0; m_rv = 1; m_err = 1; m_rd = 8'h00;
            end else begin
                m_age = m_age + 1;
            end
        end
    end

    always @(negedge PCLK) begin
        logic [29:0] act, exp;
        act = {cmd_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err};
        exp = {!m_active, m_active, (m_active && m_age >= 1), m_write, m_addr, m_wdata,
               m_rv, m_rd, m_err};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_cycle edge=%0d got %h want %h", cyc - 1, act, exp);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Drive a command and hold it until taken; returns at the negedge after the accepting edge.
    task automatic do_cmd(input logic w, input logic [7:0] a, input logic [7:0] d, output int acc);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready === 1'b1) begin
                @(negedge PCLK);
                acc = cyc - 1;
                break;
            end
            @(negedge PCLK);
        end
        cmd_valid = 1'b0;
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL accept_timeout got none want accept");
        end
    endtask

    task automatic wait_rsp(output int redge, output logic [7:0] rd, output logic er);
        redge = -1; rd = 'x; er = 'x;
        for (int i = 0; i < 50; i++) begin
            @(negedge PCLK);
            if (rsp_valid === 1'b1) begin
                redge = cyc - 1; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
        if (redge < 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout got none want rsp_valid");
        end
    endtask

    initial begin
        int a1, a2, r1, n0;
        logic [7:0] rd;
        logic er;

        // Reset state
        @(negedge PCLK);
        chk("reset_outs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err}, 0);
        chk("reset_ready", cmd_ready, 1);
        PRESET = 1'b0;
        @(negedge PCLK);

        // Zero-wait read
        PREADY = 1'b1; PRDATA = 8'hA5;
        do_cmd(1'b0, 8'h10, 8'hFF, a1);
        chk("rd_setup_psel", PSEL, 1);
        chk("rd_setup_penable", PENABLE, 0);
        chk("rd_setup_paddr", PADDR, 8'h10);
        chk("rd_pwdata_zero", PWDATA, 8'h00);
        @(negedge PCLK);
        chk("rd_access_pen", {PSEL, PENABLE}, 2'b11);
        wait_rsp(r1, rd, er);
        chk("rd_latency", r1 - a1, 2);
        chk("rd_data", rd, 8'hA5);
        chk("rd_err", er, 0);
        @(negedge PCLK);
        chk("rd_pulse_one", rsp_valid, 0);
        chk("rd_data_hold", rsp_rdata, 8'hA5);

        // Write with three wait states
        PREADY = 1'b0; PRDATA = 8'hEE;
        do_cmd(1'b1, 8'h04, 8'h3C, a1);
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            chk("wr_stable", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b111, 8'h04, 8'h3C});
        end
        PREADY = 1'b1;
        wait_rsp(r1, rd, er);
        chk("wr_latency", r1 - a1, 5);
        chk("wr_rdata_zero", rd, 8'h00);
        chk("wr_err", er, 0);
        chk("wr_psel_drop", {PSEL, PENABLE}, 2'b00);

        // Slave error, then a command taken in the response cycle
        PRDATA = 8'h77; PSLVERR = 1'b1;
        do_cmd(1'b0, 8'h20, 8'h00, a1);
        wait_rsp(r1, rd, er);
        chk("err_flag", er, 1);
        chk("err_rdata", rd, 8'h77);
        PSLVERR = 1'b0;
        do_cmd(1'b1, 8'h30, 8'h5A, a2);
        chk("err_next_accept", a2 - r1, 1);
        wait_rsp(r1, rd, er);
        chk("err_next_clean", {er, rd}, 9'h000);

        // Back-to-back commands
        PRDATA = 8'hC3;
        do_cmd(1'b0, 8'h40, 8'h00, a1);
        do_cmd(1'b0, 8'h41, 8'h00, a2);
        chk("b2b_spacing", a2 - a1, 3);
        wait_rsp(r1, rd, er);
        chk("b2b_rsp_edge", r1 - a2, 2);
        chk("b2b_rdata", rd, 8'hC3);

        // Reset in the middle of ACCESS
        PREADY = 1'b0;
        do_cmd(1'b1, 8'h50, 8'h11, a1);
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("midrst_outs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err}, 0);
        chk("midrst_ready", cmd_ready, 1);
        PRESET = 1'b0;
        PREADY = 1'b1;
        n0 = n_rsp;
        repeat (5) @(negedge PCLK);
        chk("midrst_no_rsp", n_rsp - n0, 0);

`ifdef APB_TIMEOUT_EN
        // PREADY stuck low: abort after TO ACCESS cycles
        PREADY = 1'b0; PRDATA = 8'h99;
        do_cmd(1'b0, 8'h60, 8'h00, a1);
        wait_rsp(r1, rd, er);
        chk("to_abort_latency", r1 - a1, 5);
        chk("to_abort_err", er, 1);
        chk("to_abort_rdata", rd, 8'h00);
        // PREADY rises on the last possible edge: normal completion
        do_cmd(1'b0, 8'h61, 8'h00, a1);
        repeat (3) @(negedge PCLK);
        chk("to_still_busy", {PSEL, PENABLE}, 2'b11);
        @(negedge PCLK);
        PREADY = 1'b1;
        wait_rsp(r1, rd, er);
        chk("to_win_latency", r1 - a1, 5);
        chk("to_win_err", er, 0);
        chk("to_win_rdata", rd, 8'h99);
`endif

        repeat (2) @(negedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

endmodule
